maxpool_2x2_stream: RTL and testbench

MAXPOOL_2X2_STREAM -- requirements
Module: maxpool_2x2_stream

---
 rtl/maxpool_2x2_stream_pkg.sv | 10 +
 rtl/maxpool_2x2_stream_if.sv | 25 ++
 rtl/maxpool_2x2_stream_fp_max_nonneg.sv | 22 ++
 rtl/maxpool_2x2_stream.sv | 94 +++++++++
 tb/tb_maxpool_2x2_stream.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/maxpool_2x2_stream_pkg.sv
// Shared constants for the 2x2 max-pool stream block: FP32 layout and default
// feature-map geometry.
package maxpool_2x2_stream_pkg;

  localparam int FP32_WIDTH         = 32;
  localparam int SIGN_BIT           = 31;
  localparam int DEFAULT_IMG_WIDTH  = 224;
  localparam int DEFAULT_IMG_HEIGHT = 224;

endpackage

// File: rtl/maxpool_2x2_stream_if.sv
// Activation stream in and pooled stream out for maxpool_2x2_stream.
// The slave modport is the pooling block's view.
interface maxpool_2x2_stream_if
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH
) ();

  logic                  valid_in;
  logic [DATA_WIDTH-1:0] i_data;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output valid_in, i_data,
    input  o_data, valid_out, frame_done
  );

  modport slave (
    input  valid_in, i_data,
    output o_data, valid_out, frame_done
  );

endinterface

// File: rtl/maxpool_2x2_stream_fp_max_nonneg.sv
// Max of two FP32 activations where negative inputs count as +0; non-negative
// IEEE-754 values order the same as their magnitude bits read as unsigned.
module fp_max_nonneg
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  logic [DATA_WIDTH-1:0] a_c;
  logic [DATA_WIDTH-1:0] b_c;

  always_comb begin
    a_c = a[SIGN_BIT] ? '0 : a;
    b_c = b[SIGN_BIT] ? '0 : b;
    y   = (a_c[SIGN_BIT-1:0] >= b_c[SIGN_BIT-1:0]) ? a_c : b_c;
  end

endmodule

// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 stride-2 max pool over a raster-order FP32 feature map.
// Even rows park horizontal maxima in a half-width line buffer; odd rows emit.
module maxpool_2x2_stream
  import maxpool_2x2_stream_pkg::*;
#(
  parameter int DATA_WIDTH = FP32_WIDTH,
  parameter int IMG_WIDTH  = DEFAULT_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEFAULT_IMG_HEIGHT
) (
  input logic                  clk,
  input logic                  rst_n,
  maxpool_2x2_stream_if.slave  bus
);

  localparam int CW       = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW       = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int LB_DEPTH = IMG_WIDTH / 2;
  localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] pair;
  logic [DATA_WIDTH-1:0] hmax;
  logic [DATA_WIDTH-1:0] vmax;
  logic [DATA_WIDTH-1:0] lb_rd;
  logic [LW-1:0]         lb_idx;
  logic [DATA_WIDTH-1:0] linebuf [LB_DEPTH];
  logic [DATA_WIDTH-1:0] o_data_q;
  logic                  valid_out_q;
  logic                  frame_done_q;
  logic                  col_last;
  logic                  row_last;

  assign col_last = (col == COL_LAST);
  assign row_last = (row == ROW_LAST);
  assign lb_idx   = LW'(col >> 1);
  assign lb_rd    = linebuf[lb_idx];

  fp_max_nonneg #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (
    .a (pair),
    .b (bus.i_data),
    .y (hmax)
  );

  fp_max_nonneg #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (
    .a (lb_rd),
    .b (hmax),
    .y (vmax)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      pair         <= '0;
      o_data_q     <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
        if (!col[0]) begin
          pair <= bus.i_data;
        end else if (row[0]) begin
          o_data_q     <= vmax;
          valid_out_q  <= 1'b1;
          frame_done_q <= row_last && col_last;
        end
      end
    end
  end

  // No reset: every entry is rewritten on an even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (bus.valid_in && col[0] && !row[0]) begin
      linebuf[lb_idx] <= hmax;
    end
  end

  assign bus.o_data     = o_data_q;
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Self-checking bench for maxpool_2x2_stream on a 4x4 map: window table,
// hand sequences for timing/reset corners, and random frames against a model.
module tb_maxpool_2x2_stream;
  import maxpool_2x2_stream_pkg::*;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maxpool_2x2_stream_if #(.DATA_WIDTH(32)) bus ();

  maxpool_2x2_stream #(
    .DATA_WIDTH (32),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] data;
    logic        done;
  } exp_t;

  typedef struct {
    logic [31:0] win [4];
    logic [31:0] exp;
  } vec_t;

  exp_t        exp_q [$];
  vec_t        tbl [5];
  int          checks = 0;
  int          fails = 0;
  int          out_count = 0;
  int          done_count = 0;
  logic [31:0] last_exp = '0;
  logic [31:0] last_seen = '0;
  logic [31:0] frame [N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: return {1'b0, 31'($urandom_range(0, 255))};
      2: return {1'b1, 31'($urandom)};
      3: return {2'b00, 30'($urandom)};
      default: return 32'h3F800000;
    endcase
  endfunction

  // Reference: each output is the largest ReLU'd value of its 2x2 window.
  task automatic push_exp();
    logic [31:0] m;
    logic [31:0] v;
    for (int wr = 0; wr < H / 2; wr++) begin
      for (int wc = 0; wc < W / 2; wc++) begin
        m = '0;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            v = relu(frame[(2 * wr + dr) * W + 2 * wc + dc]);
            if (v > m) m = v;
          end
        end
        exp_q.push_back('{data: m, done: (wr == H / 2 - 1) && (wc == W / 2 - 1)});
      end
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d);
    bus.valid_in = v;
    bus.i_data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, $urandom);
  endtask

  task automatic send_frame(input int max_stall);
    for (int i = 0; i < N; i++) begin
      if (max_stall > 0) idle($urandom_range(0, max_stall));
      drive(1'b1, frame[i]);
    end
  endtask

  task automatic load_ref_frame();
    for (int i = 0; i < N; i++) frame[i] = '0;
    frame[0] = 32'h3F800000;
    frame[1] = 32'h40000000;
    frame[2] = 32'h40400000;
    frame[3] = 32'h40800000;
    frame[4] = 32'h40A00000;
  endtask

  task automatic load_rand_frame();
    for (int i = 0; i < N; i++) frame[i] = rand_val();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      last_exp = '0;
      check("rst_valid_out", bus.valid_out, 32'd0);
      check("rst_frame_done", bus.frame_done, 32'd0);
      check("rst_o_data", bus.o_data, 32'd0);
    end else if (bus.valid_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_valid_out: got o_data %h with no output pending", bus.o_data);
      end else begin
        e = exp_q.pop_front();
        check("o_data", bus.o_data, e.data);
        check("frame_done", bus.frame_done, {31'd0, e.done});
        last_exp = e.data;
      end
      last_seen = bus.o_data;
      out_count++;
      if (bus.frame_done) done_count++;
    end else begin
      check("o_data_hold", bus.o_data, last_exp);
      check("frame_done_idle", bus.frame_done, 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int oc;
    int dc;

    tbl[0] = '{win: '{32'hBF800000, 32'h00000000, 32'h80000000, 32'h00000000}, exp: 32'h00000000};
    tbl[1] = '{win: '{32'h3F7FFFFF, 32'h3F800000, 32'h3F000000, 32'h00000001}, exp: 32'h3F800000};
    tbl[2] = '{win: '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h00000000}, exp: 32'h7F800000};
    tbl[3] = '{win: '{32'h80000001, 32'h00000002, 32'h00000001, 32'hFFFFFFFF}, exp: 32'h00000002};
    tbl[4] = '{win: '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000}, exp: 32'h3F800000};

    bus.valid_in = 1'b0;
    bus.i_data   = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post_reset_o_data", bus.o_data, 32'd0);
    check("post_reset_valid_out", bus.valid_out, 32'd0);

    // Reference frame, continuous: outputs exactly one cycle after row1 cols 1 and 3.
    load_ref_frame();
    push_exp();
    for (int i = 0; i < N; i++) begin
      drive(1'b1, frame[i]);
      check($sformatf("ref_valid[%0d]", i), bus.valid_out,
            {31'd0, ((i / W) % 2 == 1) && ((i % W) % 2 == 1)});
      if (i == 5) check("ref_out0", bus.o_data, 32'h40A00000);
      if (i == 7) check("ref_out1", bus.o_data, 32'h40800000);
    end
    idle(2);

    // Same frame with random stalls: same results, four outputs.
    oc = out_count;
    load_ref_frame();
    push_exp();
    send_frame(3);
    idle(2);
    check("stall_outputs", out_count - oc, 32'd4);

    // Window table: the window is tiled so every pooled output must equal exp.
    for (int t = 0; t < 5; t++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          frame[r * W + c] = tbl[t].win[(r % 2) * 2 + (c % 2)];
      push_exp();
      send_frame(0);
      idle(2);
      check($sformatf("table[%0d]", t), last_seen, tbl[t].exp);
    end

    // Two frames back to back: frame_done twice.
    oc = out_count;
    dc = done_count;
    load_ref_frame();
    push_exp();
    send_frame(0);
    load_rand_frame();
    push_exp();
    send_frame(0);
    idle(2);
    check("b2b_outputs", out_count - oc, 32'd8);
    check("b2b_frame_done", done_count - dc, 32'd2);

    // Reset after row1 col2, then a full clean frame.
    load_ref_frame();
    exp_q.push_back('{data: 32'h40A00000, done: 1'b0});
    for (int i = 0; i < 7; i++) drive(1'b1, frame[i]);
    rst_n = 1'b0;
    bus.valid_in = 1'b0;
    #1;
    check("midreset_o_data", bus.o_data, 32'd0);
    check("midreset_valid_out", bus.valid_out, 32'd0);
    check("midreset_frame_done", bus.frame_done, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    oc = out_count;
    dc = done_count;
    load_rand_frame();
    push_exp();
    send_frame(0);
    idle(2);
    check("after_reset_outputs", out_count - oc, 32'd4);
    check("after_reset_frame_done", done_count - dc, 32'd1);

    // Random frames, alternating continuous and stalled input.
    oc = out_count;
    for (int k = 0; k < 8; k++) begin
      load_rand_frame();
      push_exp();
      send_frame((k % 2) * 2);
    end
    idle(2);
    check("random_outputs", out_count - oc, 32'd32);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
